// File: rtl/irq_pkg.sv
// Shared widths, vector type and one-hot helper for the interrupt request stage.
// Latency: n/a (declarations only). Backpressure: n/a.
package irq_pkg;

  localparam int IRQ_N    = 8;
  localparam int IRQ_IDXW = 3;

  typedef logic [IRQ_N-1:0] irq_vec_t;

  // Binary index of a one-hot vector; an all-zero vector maps to 0.
  function automatic logic [IRQ_IDXW-1:0] onehot_to_idx(irq_vec_t oh);
    logic [IRQ_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      if (oh[i]) idx = idx | IRQ_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_pending_grant_if.sv
// Request/mask inputs and registered grant port of the interrupt request stage.
// Latency: n/a (wiring only). Backpressure: grant_valid/grant_ready handshake.
interface irq_pending_grant_if
  import irq_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int IDXW = IRQ_IDXW
);

  logic [N-1:0]    req;
  logic [N-1:0]    mask;
  logic            grant_valid;
  logic            grant_ready;
  logic [N-1:0]    grant_onehot;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    pending;
  logic            overflow;

  modport master (
    output req, mask, grant_ready,
    input  grant_valid, grant_onehot, grant_idx, pending, overflow
  );

  modport slave (
    input  req, mask, grant_ready,
    output grant_valid, grant_onehot, grant_idx, pending, overflow
  );

endinterface

// File: rtl/prio_pick_onehot.sv
// Combinational MSB-first one-hot pick; all-zero input gives all-zero output.
// Latency: 0 cycles. Backpressure: none.
module prio_pick_onehot #(
  parameter int N = 8
) (
  input  logic [N-1:0] in_vec,
  output logic [N-1:0] out_oh
);

  logic found;

  always_comb begin
    out_oh = '0;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i] && !found) begin
        out_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_grant.sv
// Captures request rising edges into pending and offers the highest unmasked one as a grant.
// Latency: req rise -> pending 1 cycle -> grant_valid 2 cycles. Backpressure: grant held stable while valid & ~ready.
module irq_pending_grant
  import irq_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int IDXW = IRQ_IDXW
) (
  input logic          clk,
  input logic          reset,
  irq_pending_grant_if.slave bus
);

  logic [N-1:0]    req_q;
  logic [N-1:0]    pending_q;
  logic            overflow_q;
  logic            gnt_vld_q;
  logic [N-1:0]    gnt_oh_q;
  logic [IDXW-1:0] gnt_idx_q;

  logic [N-1:0]    rise;
  logic            acc;
  logic [N-1:0]    clr;
  logic [N-1:0]    elig;
  logic [N-1:0]    cand;
  logic            gnt_load;

  assign rise     = bus.req & ~req_q;
  assign acc      = gnt_vld_q & bus.grant_ready;
  assign clr      = acc ? gnt_oh_q : '0;
  // The line being accepted this edge must not be offered again on the same edge.
  assign elig     = pending_q & ~bus.mask & ~clr;
  assign gnt_load = !gnt_vld_q || bus.grant_ready;

  prio_pick_onehot #(.N(N)) u_pick (
    .in_vec (elig),
    .out_oh (cand)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      gnt_vld_q  <= 1'b0;
      gnt_oh_q   <= '0;
      gnt_idx_q  <= '0;
    end else begin
      req_q      <= bus.req;
      // Set wins over clear so a rise on the accepting edge is never lost.
      pending_q  <= (pending_q & ~clr) | rise;
      overflow_q <= |(rise & pending_q & ~clr);
      if (gnt_load) begin
        gnt_vld_q <= |cand;
        gnt_oh_q  <= cand;
        gnt_idx_q <= onehot_to_idx(cand);
      end
    end
  end

  assign bus.grant_valid  = gnt_vld_q;
  assign bus.grant_onehot = gnt_oh_q;
  assign bus.grant_idx    = gnt_idx_q;
  assign bus.pending      = pending_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_irq_pending_grant.sv
// Directed scenarios plus randomized traffic, checked every cycle against an index-level model.
module tb_irq_pending_grant;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  irq_pending_grant_if bus ();

  irq_pending_grant dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  typedef struct packed {
    logic [7:0] reqq;
    logic [7:0] pend;
    logic       gv;
    logic [7:0] goh;
    logic [2:0] gidx;
    logic       ovf;
  } model_t;

  model_t m;

  // Model thinks in line numbers: which line rose, which line was taken, which line wins.
  function automatic model_t step(model_t s, logic [7:0] req, logic [7:0] mask, logic ready);
    model_t n;
    bit     acc;
    bit     taken;
    bit     r;
    int     sel;
    n     = s;
    acc   = s.gv && ready;
    n.ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      taken     = acc && (i == int'(s.gidx));
      r         = req[i] && !s.reqq[i];
      n.pend[i] = (s.pend[i] && !taken) || r;
      if (r && s.pend[i] && !taken) n.ovf = 1'b1;
    end
    if (!s.gv || ready) begin
      sel = -1;
      for (int i = 7; i >= 0; i--) begin
        if (sel < 0 && s.pend[i] && !mask[i] && !(acc && i == int'(s.gidx))) sel = i;
      end
      n.gv   = (sel >= 0);
      n.goh  = (sel >= 0) ? 8'(1 << sel) : 8'h00;
      n.gidx = (sel >= 0) ? 3'(sel) : 3'd0;
    end
    n.reqq = req;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, bus.req, bus.mask, bus.grant_ready);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model grant_valid", 32'(bus.grant_valid), 32'(m.gv));
      chk("model grant_onehot", 32'(bus.grant_onehot), 32'(m.goh));
      chk("model grant_idx", 32'(bus.grant_idx), 32'(m.gidx));
      chk("model pending", 32'(bus.pending), 32'(m.pend));
      chk("model overflow", 32'(bus.overflow), 32'(m.ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 30; n++) begin
      if (!bus.grant_valid && bus.pending == 8'h00) break;
      tick();
    end
    chk(name, 32'(bus.grant_valid), 32'd0);
  endtask

  logic [7:0] rq;

  initial begin
    bus.req         = 8'hFF;
    bus.mask        = 8'h00;
    bus.grant_ready = 1'b0;
    #1 reset = 1'b1;
    #2 check_en = 1'b1;

    // 1: reset with all requests held high
    tick();
    chk("rst grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst grant_onehot", 32'(bus.grant_onehot), 32'd0);
    chk("rst pending", 32'(bus.pending), 32'd0);
    chk("rst overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    tick();
    chk("t1 pending", 32'(bus.pending), 32'hFF);
    chk("t1 valid early", 32'(bus.grant_valid), 32'd0);
    tick();
    chk("t1 onehot", 32'(bus.grant_onehot), 32'h80);
    chk("t1 idx", 32'(bus.grant_idx), 32'd7);
    bus.req = 8'h00;
    bus.grant_ready = 1'b1;
    wait_idle("t1 drain");

    // 2: two lines pulsed together, drained back to back
    bus.req = 8'h05;
    tick(); bus.req = 8'h00;
    tick();
    chk("t2 first onehot", 32'(bus.grant_onehot), 32'h04);
    chk("t2 first idx", 32'(bus.grant_idx), 32'd2);
    tick();
    chk("t2 second onehot", 32'(bus.grant_onehot), 32'h01);
    chk("t2 second idx", 32'(bus.grant_idx), 32'd0);
    tick();
    chk("t2 empty valid", 32'(bus.grant_valid), 32'd0);
    chk("t2 empty pending", 32'(bus.pending), 32'd0);

    // 3: stalled grant is not overtaken by a higher line
    bus.grant_ready = 1'b0;
    bus.req = 8'h02;
    tick(); bus.req = 8'h00;
    tick();
    chk("t3 grant", 32'(bus.grant_onehot), 32'h02);
    bus.req = 8'h40;
    tick(); bus.req = 8'h00;
    chk("t3 held a", 32'(bus.grant_onehot), 32'h02);
    tick();
    chk("t3 held b", 32'(bus.grant_onehot), 32'h02);
    chk("t3 pending", 32'(bus.pending), 32'h42);
    bus.grant_ready = 1'b1;
    tick();
    chk("t3 next", 32'(bus.grant_onehot), 32'h40);
    wait_idle("t3 drain");

    // 4: masked lines wait, then drain once unmasked
    bus.mask = 8'hF0;
    bus.req = 8'h90;
    tick(); bus.req = 8'h00;
    tick();
    chk("t4 no grant", 32'(bus.grant_valid), 32'd0);
    chk("t4 pending", 32'(bus.pending), 32'h90);
    bus.mask = 8'h00;
    tick();
    chk("t4 first", 32'(bus.grant_onehot), 32'h80);
    tick();
    chk("t4 second", 32'(bus.grant_onehot), 32'h10);
    wait_idle("t4 drain");

    // 5: overflow on a re-pulse, suppressed on the accepting edge
    bus.mask = 8'h08;
    bus.req = 8'h08;
    tick(); bus.req = 8'h00;
    tick();
    bus.req = 8'h08;
    tick(); bus.req = 8'h00;
    chk("t5 overflow", 32'(bus.overflow), 32'd1);
    chk("t5 pending", 32'(bus.pending), 32'h08);
    tick();
    chk("t5 overflow pulse", 32'(bus.overflow), 32'd0);
    bus.mask = 8'h00;
    bus.grant_ready = 1'b0;
    tick();
    chk("t5 grant", 32'(bus.grant_onehot), 32'h08);
    bus.req = 8'h08;
    bus.grant_ready = 1'b1;
    tick(); bus.req = 8'h00;
    chk("t5 accept overflow", 32'(bus.overflow), 32'd0);
    chk("t5 accept pending", 32'(bus.pending), 32'h08);
    wait_idle("t5 drain");

    // 6: asynchronous reset mid-handshake
    bus.grant_ready = 1'b0;
    bus.req = 8'h01;
    tick(); bus.req = 8'h00;
    tick();
    bus.req = 8'h01;
    tick();
    chk("t6 overflow before", 32'(bus.overflow), 32'd1);
    chk("t6 valid before", 32'(bus.grant_valid), 32'd1);
    #2 reset = 1'b1;
    bus.req = 8'h00;
    #1;
    chk("t6 async valid", 32'(bus.grant_valid), 32'd0);
    chk("t6 async pending", 32'(bus.pending), 32'd0);
    chk("t6 async overflow", 32'(bus.overflow), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // randomized traffic, occasional resets
    rq = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      rq = rq ^ 8'($urandom & $urandom & $urandom);
      bus.req = rq;
      bus.mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.grant_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
